memory_access_stage: RTL and testbench
======================================

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES SHALL exist: default 64; max dmem wait cycles before bus error, legal range 2..255.
REQ-002 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  SHALL be asynchronous and active-low, forcing reset state immediately on assertion.
REQ-004 valid / memoryReadEnable / memoryWriteEnable / writeBackFromMemoryOrAlu / regWriteEnable  in  1 each  execute-to-memory register outputs: instruction present, load, store, writeback select (1=memory), register write.
REQ-005 aluResult, rs2Data, pcAdder  in  32 each  effective address / ALU result, store data, PC+4.
REQ-006 funct3  in  3  RV32I load/store size code; rd  in  5  destination register.
REQ-007 dmemReq, dmemWe  out  1 each; dmemAddr  out  32  word-aligned; dmemWdata  out  32; dmemByteEnable  out  4.
REQ-008 dmemAck  in  1  one-cycle completion; dmemRdata  in  32  valid when dmemAck=1.
REQ-009 stall  out  1  holds the execute-to-memory register and all earlier stages.
REQ-010 wbValid, wbRegWrite, wbFault, wbBusError  out  1 each; wbData, wbPcAdder  out  32 each; wbRd  out  5.

Function
REQ-011 Memory op SHALL mean valid & (memoryReadEnable | memoryWriteEnable); both enables set SHALL be treated as a store.
REQ-012 FSM states SHALL be IDLE and ACCESS only.
REQ-013 IDLE, valid non-memory op: wb outputs SHALL register the op at the next edge (1-cycle latency), stall=0, wbData=aluResult.
REQ-014 IDLE, valid=0: wbValid SHALL be 0 at the next edge; other wb outputs SHALL hold.
REQ-015 IDLE, legal aligned memory op: stall=1 combinationally, next state ACCESS, address/data/controls latched.
REQ-016 ACCESS: dmemReq=1, dmemWe=store, dmemAddr={addr[31:2],2'b00}, all held stable until dmemAck.
REQ-017 stall SHALL equal (IDLE & legal memory op) | (ACCESS & ~dmemAck); stall SHALL be 0 in the ack cycle so upstream advances.
REQ-018 On dmemAck in ACCESS: wb outputs SHALL register the completed op at that edge, next state IDLE; load latency = ack cycle + 1.
REQ-019 Halfword with addr[0]=1, word with addr[1:0]!=0, or funct3 in {3,6,7} SHALL raise fault: no dmemReq, 1-cycle pass-through with wbFault=1, wbRegWrite=0.
REQ-020 Store byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; dmemWdata SHALL replicate the byte/halfword into every lane.
REQ-021 Loads SHALL extract the lane from addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-022 wbData SHALL be the extended load data when writeBackFromMemoryOrAlu=1, else aluResult; stores SHALL force wbRegWrite=0.
REQ-023 wbPcAdder and wbRd SHALL pass through with the instruction; wbRegWrite SHALL otherwise equal regWriteEnable.
REQ-024 An 8-bit wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack.
REQ-025 When counter = TIMEOUT_CYCLES-1 and no ack: wbBusError=1, wbRegWrite=0, stall=0 that cycle, next state IDLE.
REQ-026 dmemAck in the same cycle as timeout: ack SHALL win, no bus error.
REQ-027 dmemAck while IDLE SHALL be ignored.

Reset
REQ-028 Reset SHALL force IDLE, counter 0, every wb output 0, dmemReq/dmemWe/stall 0, dmemByteEnable 0.
REQ-029 Reset asserted mid-ACCESS SHALL drop dmemReq immediately; no wb output for the aborted op.
REQ-030 First legal op after reset deassertion SHALL be accepted on the first rising edge.

Structure
REQ-031 Package memory_stage_pkg SHALL hold the FSM state enum, RV32I funct3 load/store constants and width constants.
REQ-032 Sub-module load_store_align (combinational) SHALL produce byte enables, replicated store data, extended load data and the alignment fault.
REQ-033 memory_access_stage SHALL contain the FSM, wait counter, stall logic and the writeback register.

Verification
REQ-034 SW addr 0x1000, data 0xDEADBEEF, ack after 3 cycles -> dmemByteEnable 4'b1111, stall 3 cycles, no wb register write.
REQ-035 LB addr 0x1003, dmemRdata 0x80FF_FF7F... byte 0x80 -> wbData 0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 LH addr 0x2001 -> wbFault=1 next cycle, dmemReq never asserted, stall 0.
REQ-037 LW with no ack, TIMEOUT_CYCLES=4 -> wbBusError=1 after 4 ACCESS cycles; repeat with ack at cycle 4 -> normal load, no error.
REQ-038 Reset asserted during ACCESS -> dmemReq 0 immediately, all wb outputs 0, IDLE; next ADD-type op completes in 1 cycle.

Source files
------------

// File: rtl/memory_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_stage_pkg
//  Description : Shared types and constants for the memory-access stage:
//                FSM state encoding, RV32I load/store funct3 codes, widths,
//                and a helper that flags funct3 codes with no RV32I meaning.
//  Revision    : 1.0  initial release
// ============================================================================
package memory_stage_pkg;

    localparam int unsigned c_xlen   = 32;
    localparam int unsigned c_be_w   = 4;
    localparam int unsigned c_rd_w   = 5;
    localparam int unsigned c_f3_wd  = 3;
    localparam int unsigned c_wait_w = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Load encodings
    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;
    // Store encodings
    localparam logic [2:0] c_f3_sb  = 3'b000;
    localparam logic [2:0] c_f3_sh  = 3'b001;
    localparam logic [2:0] c_f3_sw  = 3'b010;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_align
//  Description : Combinational lane steering for RV32I loads and stores.
//  Ports       : funct3      - size/sign code
//                addr_lsb    - byte offset within the word
//                store_data  - raw rs2 value
//                load_raw    - word returned by data memory
//                byte_enable - per-lane write enables
//                store_wdata - store value replicated into every lane
//                load_data   - selected lane, sign/zero extended
//                fault       - misaligned access or undefined funct3
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_align
    import memory_stage_pkg::*;
(
    input  logic [c_f3_wd-1:0] funct3,
    input  logic [1:0]         addr_lsb,
    input  logic [c_xlen-1:0]  store_data,
    input  logic [c_xlen-1:0]  load_raw,
    output logic [c_be_w-1:0]  byte_enable,
    output logic [c_xlen-1:0]  store_wdata,
    output logic [c_xlen-1:0]  load_data,
    output logic               fault
);

    logic [c_xlen-1:0] w_shifted;
    logic [1:0]        w_size;

    // Bring the addressed lane down to bit 0 before extension.
    assign w_shifted = load_raw >> {addr_lsb, 3'b000};
    assign w_size    = funct3[1:0];

    always_comb begin
        byte_enable = 4'b1111;
        store_wdata = store_data;
        case (w_size)
            c_f3_sb[1:0]: begin
                byte_enable = 4'b0001 << addr_lsb;
                store_wdata = {4{store_data[7:0]}};
            end
            c_f3_sh[1:0]: begin
                byte_enable = 4'b0011 << addr_lsb;
                store_wdata = {2{store_data[15:0]}};
            end
            c_f3_sw[1:0]: begin
                byte_enable = 4'b1111;
                store_wdata = store_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data = load_raw;
        case (funct3)
            c_f3_lb:  load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_f3_lh:  load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_f3_lbu: load_data = {24'd0, w_shifted[7:0]};
            c_f3_lhu: load_data = {16'd0, w_shifted[15:0]};
            c_f3_lw:  load_data = load_raw;
            default:  load_data = load_raw;
        endcase
    end

    // funct3[1:0]==2'b10 covers LW/SW; 3'b110 is already caught as undefined.
    assign fault = f3_illegal(funct3)
                 | ((w_size == 2'b01) & addr_lsb[0])
                 | ((w_size == 2'b10) & (addr_lsb != 2'b00));

endmodule
`default_nettype wire

// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : memory_access_stage
//  Description : RV32I memory stage. Non-memory ops and faulting accesses
//                pass to writeback in one cycle; legal loads/stores hold the
//                pipeline while a request is presented to data memory until
//                it acknowledges or the wait counter times out.
//  Ports       : clock/reset      - rising-edge clock, async active-low reset
//                valid..rd        - execute-to-memory register contents
//                dmem*            - data memory request/response
//                stall            - freezes the EX/MEM register and earlier
//                wb*              - writeback register
//  Revision    : 1.0  initial release
// ============================================================================
module memory_access_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                valid,
    input  logic                memoryReadEnable,
    input  logic                memoryWriteEnable,
    input  logic                writeBackFromMemoryOrAlu,
    input  logic                regWriteEnable,
    input  logic [c_xlen-1:0]   aluResult,
    input  logic [c_xlen-1:0]   rs2Data,
    input  logic [c_xlen-1:0]   pcAdder,
    input  logic [c_f3_wd-1:0]  funct3,
    input  logic [c_rd_w-1:0]   rd,
    output logic                dmemReq,
    output logic                dmemWe,
    output logic [c_xlen-1:0]   dmemAddr,
    output logic [c_xlen-1:0]   dmemWdata,
    output logic [c_be_w-1:0]   dmemByteEnable,
    input  logic                dmemAck,
    input  logic [c_xlen-1:0]   dmemRdata,
    output logic                stall,
    output logic                wbValid,
    output logic                wbRegWrite,
    output logic                wbFault,
    output logic                wbBusError,
    output logic [c_xlen-1:0]   wbData,
    output logic [c_xlen-1:0]   wbPcAdder,
    output logic [c_rd_w-1:0]   wbRd
);

    localparam logic [c_wait_w-1:0] c_timeout_last = c_wait_w'(TIMEOUT_CYCLES - 1);

    state_t r_state;
    state_t w_next_state;

    logic [c_wait_w-1:0] r_wait_cnt;
    logic [c_xlen-1:0]   r_addr;
    logic [c_xlen-1:0]   r_sdata;
    logic [c_xlen-1:0]   r_pc;
    logic [c_rd_w-1:0]   r_rd;
    logic [c_f3_wd-1:0]  r_f3;
    logic                r_store;
    logic                r_wbsel;
    logic                r_regwrite;

    logic                w_access;
    logic                w_mem_op;
    logic                w_fault;
    logic                w_legal;
    logic                w_timeout;
    logic [c_f3_wd-1:0]  w_al_f3;
    logic [1:0]          w_al_lsb;
    logic [c_xlen-1:0]   w_al_sdata;
    logic [c_be_w-1:0]   w_byte_enable;
    logic [c_xlen-1:0]   w_store_wdata;
    logic [c_xlen-1:0]   w_load_data;

    assign w_access = (r_state == ST_ACCESS);
    assign w_mem_op = valid & (memoryReadEnable | memoryWriteEnable);
    assign w_legal  = w_mem_op & ~w_fault;
    assign w_timeout = w_access & ~dmemAck & (r_wait_cnt == c_timeout_last);

    // One aligner serves both phases: the fault check only matters in IDLE
    // (live inputs), lane steering only in ACCESS (latched op).
    assign w_al_f3    = w_access ? r_f3          : funct3;
    assign w_al_lsb   = w_access ? r_addr[1:0]   : aluResult[1:0];
    assign w_al_sdata = w_access ? r_sdata       : rs2Data;

    load_store_align u_align (
        .funct3      (w_al_f3),
        .addr_lsb    (w_al_lsb),
        .store_data  (w_al_sdata),
        .load_raw    (dmemRdata),
        .byte_enable (w_byte_enable),
        .store_wdata (w_store_wdata),
        .load_data   (w_load_data),
        .fault       (w_fault)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_legal) w_next_state = ST_ACCESS;
            ST_ACCESS: if (dmemAck || w_timeout) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Output logic; stall is forced low while reset is held.
    always_comb begin
        stall          = 1'b0;
        dmemReq        = 1'b0;
        dmemWe         = 1'b0;
        dmemAddr       = '0;
        dmemWdata      = '0;
        dmemByteEnable = '0;
        if (reset) begin
            case (r_state)
                ST_IDLE: stall = w_legal;
                ST_ACCESS: begin
                    dmemReq        = 1'b1;
                    dmemWe         = r_store;
                    dmemAddr       = {r_addr[31:2], 2'b00};
                    dmemWdata      = w_store_wdata;
                    dmemByteEnable = w_byte_enable;
                    stall          = ~dmemAck & ~w_timeout;
                end
                default: ;
            endcase
        end
    end

    // Wait counter and operand capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_sdata    <= '0;
            r_pc       <= '0;
            r_rd       <= '0;
            r_f3       <= '0;
            r_store    <= 1'b0;
            r_wbsel    <= 1'b0;
            r_regwrite <= 1'b0;
        end else if (!w_access) begin
            if (w_legal) begin
                r_wait_cnt <= '0;
                r_addr     <= aluResult;
                r_sdata    <= rs2Data;
                r_pc       <= pcAdder;
                r_rd       <= rd;
                r_f3       <= funct3;
                r_store    <= memoryWriteEnable;
                r_wbsel    <= writeBackFromMemoryOrAlu;
                r_regwrite <= regWriteEnable;
            end
        end else if (!dmemAck) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // Writeback register: only wbValid is refreshed on idle cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wbValid    <= 1'b0;
            wbRegWrite <= 1'b0;
            wbFault    <= 1'b0;
            wbBusError <= 1'b0;
            wbData     <= '0;
            wbPcAdder  <= '0;
            wbRd       <= '0;
        end else if (!w_access) begin
            if (valid && !w_legal) begin
                // Non-memory op, or a memory op rejected by the aligner.
                wbValid    <= 1'b1;
                wbRegWrite <= regWriteEnable & ~w_mem_op;
                wbFault    <= w_mem_op;
                wbBusError <= 1'b0;
                wbData     <= aluResult;
                wbPcAdder  <= pcAdder;
                wbRd       <= rd;
            end else begin
                wbValid    <= 1'b0;
            end
        end else if (dmemAck) begin
            wbValid    <= 1'b1;
            wbRegWrite <= r_regwrite & ~r_store;
            wbFault    <= 1'b0;
            wbBusError <= 1'b0;
            wbData     <= r_wbsel ? w_load_data : r_addr;
            wbPcAdder  <= r_pc;
            wbRd       <= r_rd;
        end else if (w_timeout) begin
            wbValid    <= 1'b1;
            wbRegWrite <= 1'b0;
            wbFault    <= 1'b0;
            wbBusError <= 1'b1;
            wbData     <= r_addr;
            wbPcAdder  <= r_pc;
            wbRd       <= r_rd;
        end else begin
            wbValid    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_access_stage
//  Description : Directed scoreboard bench for memory_access_stage with a
//                short timeout so the bus-error path is reachable.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_access_stage;

    localparam int unsigned TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0, re = 1'b0, we = 1'b0, wsel = 1'b0, rw = 1'b0;
    logic [31:0] alu = '0, rs2 = '0, pc = '0;
    logic [2:0]  f3 = '0;
    logic [4:0]  rd = '0;
    logic        dmemReq, dmemWe, dmemAck = 1'b0;
    logic [31:0] dmemAddr, dmemWdata, dmemRdata = '0;
    logic [3:0]  dmemByteEnable;
    logic        stall, wbValid, wbRegWrite, wbFault, wbBusError;
    logic [31:0] wbData, wbPcAdder;
    logic [4:0]  wbRd;

    memory_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .valid(valid),
        .memoryReadEnable(re), .memoryWriteEnable(we),
        .writeBackFromMemoryOrAlu(wsel), .regWriteEnable(rw),
        .aluResult(alu), .rs2Data(rs2), .pcAdder(pc), .funct3(f3), .rd(rd),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
        .dmemWdata(dmemWdata), .dmemByteEnable(dmemByteEnable),
        .dmemAck(dmemAck), .dmemRdata(dmemRdata), .stall(stall),
        .wbValid(wbValid), .wbRegWrite(wbRegWrite), .wbFault(wbFault),
        .wbBusError(wbBusError), .wbData(wbData), .wbPcAdder(wbPcAdder),
        .wbRd(wbRd)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rwe;
        logic        flt;
        logic        berr;
        logic        chk_data;
        logic [31:0] data;
        logic [31:0] pcv;
        logic [4:0]  rdv;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", nm, act, exp);
        end
    endtask

    // Memory responder: acks in the ack_at-th ACCESS cycle (0 = never).
    int          ack_at = 0;
    int          acc_cnt = 0;
    logic [31:0] rdata_v = '0;
    logic        ack_idle_inject = 1'b0;
    always @(posedge clock) begin
        #2;
        if (dmemReq) begin
            acc_cnt++;
            dmemAck   = (ack_at != 0) && (acc_cnt == ack_at);
            dmemRdata = rdata_v;
        end else begin
            acc_cnt   = 0;
            dmemAck   = ack_idle_inject;
            dmemRdata = rdata_v;
        end
    end

    // Monitor: every cycle with wbValid high retires exactly one op.
    always @(negedge clock) begin
        if (reset && wbValid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wbRegWrite", {31'd0, wbRegWrite}, {31'd0, e.rwe});
                chk("wbFault",    {31'd0, wbFault},    {31'd0, e.flt});
                chk("wbBusError", {31'd0, wbBusError}, {31'd0, e.berr});
                if (e.chk_data) chk("wbData", wbData, e.data);
                chk("wbPcAdder", wbPcAdder, e.pcv);
                chk("wbRd", {27'd0, wbRd}, {27'd0, e.rdv});
            end
        end
    end

    task automatic expect_wb(input logic rwe, input logic flt, input logic berr,
                             input logic cd, input logic [31:0] d,
                             input logic [31:0] p, input logic [4:0] r);
        exp_t e;
        e.rwe = rwe; e.flt = flt; e.berr = berr; e.chk_data = cd;
        e.data = d; e.pcv = p; e.rdv = r;
        sb.push_back(e);
    endtask

    task automatic drive(input logic i_re, input logic i_we, input logic i_wsel,
                         input logic i_rw, input logic [2:0] i_f3,
                         input logic [31:0] i_alu, input logic [31:0] i_rs2,
                         input logic [31:0] i_pc, input logic [4:0] i_rd);
        valid = 1'b1; re = i_re; we = i_we; wsel = i_wsel; rw = i_rw;
        f3 = i_f3; alu = i_alu; rs2 = i_rs2; pc = i_pc; rd = i_rd;
    endtask

    // Called just after a rising edge with the op already driven.
    task automatic run_op(input string nm, input int exp_stall, input logic exp_req,
                          input logic [31:0] e_addr, input logic e_we,
                          input logic [3:0] e_be, input logic [31:0] e_wd);
        int   st = 0;
        logic req_seen = 1'b0;
        logic done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clock);
            if (dmemReq && !req_seen) begin
                req_seen = 1'b1;
                chk({nm, "_addr"}, dmemAddr, e_addr);
                chk({nm, "_we"}, {31'd0, dmemWe}, {31'd0, e_we});
                chk({nm, "_be"}, {28'd0, dmemByteEnable}, {28'd0, e_be});
                if (e_we) chk({nm, "_wdata"}, dmemWdata, e_wd);
            end
            if (stall) st++;
            else done = 1'b1;
            @(posedge clock);
            #1;
        end
        if (!done) chk({nm, "_hang"}, 32'd1, 32'd0);
        valid = 1'b0;
        chk({nm, "_stall_cycles"}, st, exp_stall);
        chk({nm, "_req_seen"}, {31'd0, req_seen}, {31'd0, exp_req});
    endtask

    task automatic idle_cycle(input logic [4:0] hold_rd);
        @(negedge clock);
        @(negedge clock);
        chk("idle_wbValid", {31'd0, wbValid}, 32'd0);
        chk("idle_wbRd_hold", {27'd0, wbRd}, {27'd0, hold_rd});
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_wbValid", {31'd0, wbValid}, 32'd0);
        chk("rst_wbData", wbData, 32'd0);
        chk("rst_wbRd", {27'd0, wbRd}, 32'd0);
        chk("rst_dmemReq", {31'd0, dmemReq}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_be", {28'd0, dmemByteEnable}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // ALU op: single-cycle pass-through
        drive(0, 0, 0, 1, 3'd0, 32'h1234_5678, 32'h0, 32'h0000_0104, 5'd5);
        expect_wb(1, 0, 0, 1, 32'h1234_5678, 32'h104, 5'd5);
        run_op("add", 0, 0, 0, 0, 0, 0);
        idle_cycle(5'd5);

        // SW, ack in third ACCESS cycle; regWrite requested but forced off
        ack_at = 3;
        drive(0, 1, 0, 1, 3'd2, 32'h0000_1000, 32'hDEAD_BEEF, 32'h108, 5'd6);
        expect_wb(0, 0, 0, 1, 32'h0000_1000, 32'h108, 5'd6);
        run_op("sw", 3, 1, 32'h1000, 1, 4'b1111, 32'hDEAD_BEEF);

        // SB / SH lane steering and replication
        ack_at = 1;
        drive(0, 1, 0, 0, 3'd0, 32'h0000_1002, 32'h0000_00AB, 32'h10C, 5'd0);
        expect_wb(0, 0, 0, 1, 32'h0000_1002, 32'h10C, 5'd0);
        run_op("sb", 1, 1, 32'h1000, 1, 4'b0100, 32'hABAB_ABAB);
        drive(0, 1, 0, 0, 3'd1, 32'h0000_1002, 32'h1234_CDEF, 32'h110, 5'd0);
        expect_wb(0, 0, 0, 1, 32'h0000_1002, 32'h110, 5'd0);
        run_op("sh", 1, 1, 32'h1000, 1, 4'b1100, 32'hCDEF_CDEF);

        // Loads with extension
        ack_at = 2; rdata_v = 32'h80FF_FF7F;
        drive(1, 0, 1, 1, 3'd0, 32'h0000_1003, 32'h0, 32'h114, 5'd7);
        expect_wb(1, 0, 0, 1, 32'hFFFF_FF80, 32'h114, 5'd7);
        run_op("lb", 2, 1, 32'h1000, 0, 4'b1000, 0);
        drive(1, 0, 1, 1, 3'd4, 32'h0000_1003, 32'h0, 32'h118, 5'd8);
        expect_wb(1, 0, 0, 1, 32'h0000_0080, 32'h118, 5'd8);
        run_op("lbu", 2, 1, 32'h1000, 0, 4'b1000, 0);
        rdata_v = 32'h8001_1234;
        drive(1, 0, 1, 1, 3'd1, 32'h0000_2002, 32'h0, 32'h11C, 5'd9);
        expect_wb(1, 0, 0, 1, 32'hFFFF_8001, 32'h11C, 5'd9);
        run_op("lh", 2, 1, 32'h2000, 0, 4'b1100, 0);
        drive(1, 0, 1, 1, 3'd5, 32'h0000_2000, 32'h0, 32'h120, 5'd10);
        expect_wb(1, 0, 0, 1, 32'h0000_1234, 32'h120, 5'd10);
        run_op("lhu", 2, 1, 32'h2000, 0, 4'b0011, 0);

        // Ack coinciding with the timeout cycle: ack wins
        ack_at = 4; rdata_v = 32'hCAFE_F00D;
        drive(1, 0, 1, 1, 3'd2, 32'h0000_3000, 32'h0, 32'h124, 5'd11);
        expect_wb(1, 0, 0, 1, 32'hCAFE_F00D, 32'h124, 5'd11);
        run_op("lw_ack_at_to", 4, 1, 32'h3000, 0, 4'b1111, 0);

        // Alignment / encoding faults: no request, no stall
        drive(1, 0, 1, 1, 3'd1, 32'h0000_2001, 32'h0, 32'h128, 5'd12);
        expect_wb(0, 1, 0, 1, 32'h0000_2001, 32'h128, 5'd12);
        run_op("lh_mis", 0, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 1, 3'd2, 32'h0000_3002, 32'h0, 32'h12C, 5'd13);
        expect_wb(0, 1, 0, 1, 32'h0000_3002, 32'h12C, 5'd13);
        run_op("lw_mis", 0, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 1, 3'd3, 32'h0000_3000, 32'h0, 32'h130, 5'd14);
        expect_wb(0, 1, 0, 1, 32'h0000_3000, 32'h130, 5'd14);
        run_op("f3_3", 0, 0, 0, 0, 0, 0);

        // No ack at all: bus error after TO ACCESS cycles
        ack_at = 0;
        drive(1, 0, 1, 1, 3'd2, 32'h0000_4000, 32'h0, 32'h134, 5'd15);
        expect_wb(0, 0, 1, 0, 32'h0, 32'h134, 5'd15);
        run_op("lw_timeout", 4, 1, 32'h4000, 0, 4'b1111, 0);
        idle_cycle(5'd15);

        // Stray ack while idle is ignored
        ack_idle_inject = 1'b1;
        idle_cycle(5'd15);
        drive(0, 0, 0, 1, 3'd0, 32'h0000_0042, 32'h0, 32'h138, 5'd16);
        expect_wb(1, 0, 0, 1, 32'h0000_0042, 32'h138, 5'd16);
        run_op("add_stray_ack", 0, 0, 0, 0, 0, 0);
        ack_idle_inject = 1'b0;

        // Reset during ACCESS
        ack_at = 0;
        drive(1, 0, 1, 1, 3'd2, 32'h0000_5000, 32'h0, 32'h13C, 5'd17);
        @(negedge clock);
        chk("mid_idle_stall", {31'd0, stall}, 32'd1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("mid_access_req", {31'd0, dmemReq}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("arst_dmemReq", {31'd0, dmemReq}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_wbValid", {31'd0, wbValid}, 32'd0);
        chk("arst_wbRegWrite", {31'd0, wbRegWrite}, 32'd0);
        chk("arst_wbData", wbData, 32'd0);
        chk("arst_wbRd", {27'd0, wbRd}, 32'd0);
        chk("arst_be", {28'd0, dmemByteEnable}, 32'd0);
        valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        drive(0, 0, 0, 1, 3'd0, 32'h0000_0055, 32'h0, 32'h200, 5'd9);
        expect_wb(1, 0, 0, 1, 32'h0000_0055, 32'h200, 5'd9);
        run_op("add_after_rst", 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clock);
        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
